// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 (RC4) encryption engine.
//
// Reads a length-prefixed plaintext from pt memory (pt[0] = length), runs the
// RC4 key schedule into an external S memory with a KEY_W-bit key, and writes
// the length-prefixed ciphertext (ct[0] = length) to ct memory.
//
// All memories are single-port, synchronous, with 1-cycle read latency.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high (aborts any run, returns to idle)
//   en         start request, sampled only while rdy=1
//   rdy        high when idle and able to accept en
//   key        encryption key, key[KEY_W-1 -: 8] is key byte 0
//   s_addr     S memory address
//   s_rddata   S memory read data
//   s_wrdata   S memory write data
//   s_wren     S memory write enable
//   pt_addr    plaintext memory address
//   pt_rddata  plaintext memory read data
//   ct_addr    ciphertext memory address
//   ct_wrdata  ciphertext memory write data
//   ct_wren    ciphertext memory write enable
//
// Optional feature (macro ARC4_ENC_ZERO_FILL_EN): when defined, ct[len+1..255]
// are written with 0x00 after the message, one per cycle.

module arc4_encrypt #(
    parameter int KEY_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic [7:0]       s_addr,
    input  logic [7:0]       s_rddata,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic [7:0]       ct_addr,
    output logic [7:0]       ct_wrdata,
    output logic             ct_wren
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RI,
        KSA_RJ,
        KSA_WI,
        KSA_WJ,
        LEN_RD,
        LEN_WR,
        PRGA_RI,
        PRGA_RJ,
        PRGA_WI,
        PRGA_WJ,
        PRGA_RP,
        PRGA_WC
`ifdef ARC4_ENC_ZERO_FILL_EN
        , ZFILL
`endif
    } state_t;

    state_t state, state_next;

    logic [7:0]       i, j;
    logic [7:0]       si, sj;
    logic [7:0]       len;
    logic [8:0]       k;
    logic [KEY_W-1:0] key_rot;

    logic [7:0] key_byte;
    logic [7:0] i_next;
    logic [7:0] ksa_j;
    logic [7:0] prga_j;
    logic [7:0] pad_addr;

    // The latched key is rotated one byte per KSA step, so its top byte is
    // always keybyte[i mod (KEY_W/8)] without needing a modulo counter.
    assign key_byte = key_rot[KEY_W-1 -: 8];
    assign i_next   = i + 8'd1;
    assign ksa_j    = j + s_rddata + key_byte;
    assign prga_j   = j + s_rddata;
    // After the swap S[i]=sj and S[j]=si; the sum is the same either way.
    assign pad_addr = si + sj;

    assign rdy = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i       <= '0;
            j       <= '0;
            si      <= '0;
            sj      <= '0;
            len     <= '0;
            k       <= '0;
            key_rot <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        key_rot <= key;
                        i       <= '0;
                    end
                end
                INIT: begin
                    // i wraps to 0 after 255, ready for the KSA pass.
                    i <= i_next;
                    j <= '0;
                end
                KSA_RJ: begin
                    si <= s_rddata;
                    j  <= ksa_j;
                end
                KSA_WJ: begin
                    i       <= i_next;
                    key_rot <= (key_rot << 8) | (key_rot >> (KEY_W - 8));
                end
                LEN_WR: begin
                    len <= pt_rddata;
                    i   <= '0;
                    j   <= '0;
                    k   <= 9'd1;
                end
                PRGA_RI: begin
                    i <= i_next;
                end
                PRGA_RJ: begin
                    si <= s_rddata;
                    j  <= prga_j;
                end
                PRGA_WI: begin
                    sj <= s_rddata;
                end
                PRGA_WC: begin
                    k <= k + 9'd1;
                end
`ifdef ARC4_ENC_ZERO_FILL_EN
                ZFILL: begin
                    k <= k + 9'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Each memory read is issued one state before its data is consumed; the
    // consuming state sees the data on *_rddata thanks to the 1-cycle latency.
    always_comb begin
        state_next = state;
        s_addr     = '0;
        s_wrdata   = '0;
        s_wren     = 1'b0;
        pt_addr    = '0;
        ct_addr    = '0;
        ct_wrdata  = '0;
        ct_wren    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                if (i == 8'd255) begin
                    state_next = KSA_RI;
                end
            end
            KSA_RI: begin
                s_addr     = i;
                state_next = KSA_RJ;
            end
            KSA_RJ: begin
                s_addr     = ksa_j;
                state_next = KSA_WI;
            end
            KSA_WI: begin
                s_addr     = i;
                s_wrdata   = s_rddata;
                s_wren     = 1'b1;
                state_next = KSA_WJ;
            end
            KSA_WJ: begin
                s_addr     = j;
                s_wrdata   = si;
                s_wren     = 1'b1;
                state_next = (i == 8'd255) ? LEN_RD : KSA_RI;
            end
            LEN_RD: begin
                pt_addr    = 8'd0;
                state_next = LEN_WR;
            end
            LEN_WR: begin
                ct_addr   = 8'd0;
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                if (pt_rddata != 8'd0) begin
                    state_next = PRGA_RI;
                end else begin
`ifdef ARC4_ENC_ZERO_FILL_EN
                    state_next = ZFILL;
`else
                    state_next = IDLE;
`endif
                end
            end
            PRGA_RI: begin
                s_addr     = i_next;
                state_next = PRGA_RJ;
            end
            PRGA_RJ: begin
                s_addr     = prga_j;
                state_next = PRGA_WI;
            end
            PRGA_WI: begin
                s_addr     = i;
                s_wrdata   = s_rddata;
                s_wren     = 1'b1;
                state_next = PRGA_WJ;
            end
            PRGA_WJ: begin
                s_addr     = j;
                s_wrdata   = si;
                s_wren     = 1'b1;
                state_next = PRGA_RP;
            end
            PRGA_RP: begin
                s_addr     = pad_addr;
                pt_addr    = k[7:0];
                state_next = PRGA_WC;
            end
            PRGA_WC: begin
                ct_addr   = k[7:0];
                ct_wrdata = pt_rddata ^ s_rddata;
                ct_wren   = 1'b1;
                // k is 9 bits so the len=255 case ends here instead of wrapping.
                if (k == {1'b0, len}) begin
`ifdef ARC4_ENC_ZERO_FILL_EN
                    state_next = (k == 9'd255) ? IDLE : ZFILL;
`else
                    state_next = IDLE;
`endif
                end else begin
                    state_next = PRGA_RI;
                end
            end
`ifdef ARC4_ENC_ZERO_FILL_EN
            ZFILL: begin
                ct_addr   = k[7:0];
                ct_wrdata = 8'h00;
                ct_wren   = 1'b1;
                if (k == 9'd255) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: self-checking bench for arc4_encrypt.
//
// Models the S, pt and ct memories as 1-cycle-latency synchronous RAMs and
// compares the engine's ciphertext and final S permutation against a plain
// RC4 reference computed inside the bench. Honours ARC4_ENC_ZERO_FILL_EN.

module tb_arc4_encrypt;

    localparam int KEY_W = 24;
    localparam int KB    = KEY_W / 8;
    localparam int MAX_CYCLES = 6000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             rdy;
    logic [KEY_W-1:0] key;
    logic [7:0]       s_addr, s_rddata, s_wrdata;
    logic             s_wren;
    logic [7:0]       pt_addr, pt_rddata;
    logic [7:0]       ct_addr, ct_wrdata;
    logic             ct_wren;

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];

    int ref_s   [256];
    int ref_in  [256];
    int ref_out [256];
    int std_ct  [10] = '{'h09, 'hBB, 'hF3, 'h16, 'hE8, 'hD9, 'h40, 'hAF, 'h0A, 'hD3};

    int passes = 0;
    int checks = 0;

    arc4_encrypt #(.KEY_W(KEY_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memories with registered read data.
    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int key_byte(input logic [KEY_W-1:0] k, input int n);
        logic [KEY_W-1:0] t;
        t = k >> (8 * (KB - 1 - n));
        return int'(t[7:0]);
    endfunction

    // Textbook RC4 over ref_in (length-prefixed) into ref_out; ref_s keeps
    // the permutation left after the keystream generation.
    task automatic ref_rc4(input logic [KEY_W-1:0] k);
        int i, j, t, n, pad;
        for (int a = 0; a < 256; a++) ref_s[a] = a;
        j = 0;
        for (i = 0; i < 256; i++) begin
            j = (j + ref_s[i] + key_byte(k, i % KB)) % 256;
            t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
        end
        n = ref_in[0];
        ref_out[0] = n;
        i = 0;
        j = 0;
        for (int c = 1; c <= n; c++) begin
            i = (i + 1) % 256;
            j = (j + ref_s[i]) % 256;
            t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
            pad = ref_s[(ref_s[i] + ref_s[j]) % 256];
            ref_out[c] = ref_in[c] ^ pad;
        end
    endtask

    // Runs one message already loaded into pt_mem and checks everything.
    // With disturb set, en is pulsed and the key changed mid-run.
    task automatic applyStimulus(input logic [KEY_W-1:0] run_key, input string tag, input bit disturb);
        int n, cyc, wr, last, done, mism, exp_wr, exp_b;
        n = int'(pt_mem[0]);
        for (int a = 0; a < 256; a++) ref_in[a] = int'(pt_mem[a]);
        ref_rc4(run_key);
        for (int a = 0; a < 256; a++) ct_mem[a] <= 8'hA5;
        @(negedge clk);
        key = run_key;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checkOutput({tag, "/start_rdy"}, rdy, 0);
        cyc = 0; wr = 0; last = -1; done = 0;
        while (cyc < MAX_CYCLES && done == 0) begin
            if (ct_wren) begin
                wr++;
                last = cyc;
            end
            if (rdy) begin
                done = 1;
            end else begin
                if (disturb && cyc == 40) begin
                    en  = 1'b1;
                    key = ~run_key;
                end
                if (disturb && cyc == 41) en = 1'b0;
                if (disturb && cyc == 700) key = 24'h123456;
                @(negedge clk);
                cyc++;
            end
        end
        en = 1'b0;
        checkOutput({tag, "/done"}, done, 1);
        checkOutput({tag, "/rdy_after_last_write"}, cyc, last + 1);
`ifdef ARC4_ENC_ZERO_FILL_EN
        exp_wr = 256;
`else
        exp_wr = n + 1;
`endif
        checkOutput({tag, "/ct_write_count"}, wr, exp_wr);
        for (int a = 0; a < 256; a++) begin
`ifdef ARC4_ENC_ZERO_FILL_EN
            exp_b = (a <= n) ? ref_out[a] : 0;
`else
            exp_b = (a <= n) ? ref_out[a] : 'hA5;
`endif
            checkOutput($sformatf("%s/ct[%0d]", tag, a), ct_mem[a], exp_b);
        end
        mism = 0;
        for (int a = 0; a < 256; a++) if (int'(s_mem[a]) != ref_s[a]) mism++;
        checkOutput({tag, "/s_final_mismatches"}, mism, 0);
        // Decrypt the engine's ciphertext with the same key.
        for (int a = 0; a < 256; a++) ref_in[a] = int'(ct_mem[a]);
        ref_rc4(run_key);
        mism = 0;
        for (int a = 1; a <= n; a++) if (ref_out[a] != int'(pt_mem[a])) mism++;
        checkOutput({tag, "/roundtrip_mismatches"}, mism, 0);
    endtask

    task automatic load_string(input string msg);
        for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
        pt_mem[0] = 8'(msg.len());
        for (int c = 0; c < msg.len(); c++) pt_mem[c + 1] = msg[c];
    endtask

    task automatic load_random(input int n);
        for (int a = 0; a < 256; a++) pt_mem[a] = 8'($urandom_range(0, 255));
        pt_mem[0] = 8'(n);
    endtask

    initial begin
        int wcount, rcount;
        rst = 1'b1;
        en  = 1'b0;
        key = '0;
        for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset/rdy", rdy, 1);
        checkOutput("reset/s_wren", s_wren, 0);
        checkOutput("reset/ct_wren", ct_wren, 0);
        checkOutput("reset/s_addr", s_addr, 0);
        checkOutput("reset/pt_addr", pt_addr, 0);
        checkOutput("reset/ct_addr", ct_addr, 0);

        // rst and en together: reset wins, no start.
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        checkOutput("rst_en/rdy", rdy, 1);

        // Standard vector against fixed constants.
        load_string("Plaintext");
        applyStimulus(24'h4B6579, "std", 1'b0);
        for (int a = 0; a < 10; a++) checkOutput($sformatf("std_const[%0d]", a), ct_mem[a], std_ct[a]);

        // Same vector with en pulsed and key changed mid-run.
        applyStimulus(24'h4B6579, "std_disturb", 1'b1);
        for (int a = 0; a < 10; a++) checkOutput($sformatf("disturb_const[%0d]", a), ct_mem[a], std_ct[a]);

        load_random(0);
        applyStimulus(24'h000018, "len0", 1'b0);

        load_string("Round trip ASCII text for ARC4 engine!!!");
        applyStimulus(24'h000018, "ascii40", 1'b0);

        load_random(255);
        applyStimulus(24'($urandom), "len255", 1'b0);

        load_random(1);
        applyStimulus(24'($urandom), "len1", 1'b0);

        for (int r = 0; r < 2; r++) begin
            load_random($urandom_range(2, 254));
            applyStimulus(24'($urandom), $sformatf("rand%0d", r), 1'b0);
        end

        // Abort in the middle of the key schedule.
        load_string("Plaintext");
        key = 24'h4B6579;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (400) @(negedge clk);
        checkOutput("abort/busy_before", rdy, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort/rdy", rdy, 1);
        checkOutput("abort/s_wren", s_wren, 0);
        checkOutput("abort/ct_wren", ct_wren, 0);
        wcount = 0;
        rcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (s_wren || ct_wren) wcount++;
            if (!rdy) rcount++;
            @(negedge clk);
        end
        checkOutput("abort/writes_after", wcount, 0);
        checkOutput("abort/rdy_low_after", rcount, 0);

        // A fresh run after the abort still produces the standard vector.
        applyStimulus(24'h4B6579, "after_abort", 1'b0);
        for (int a = 0; a < 10; a++) checkOutput($sformatf("after_abort_const[%0d]", a), ct_mem[a], std_ct[a]);

        $display("[TB] done");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- ARC4 (RC4) encryption engine. It is the write-side counterpart of the cracking/decrypt path.
- Reads a length-prefixed plaintext message from pt memory and runs the key schedule with a 24-bit key into an external S memory.
- Writes the length-prefixed ciphertext to ct memory, where the crack/decrypt blocks consume it.
- Sits under the top-level task wrapper and uses the standard en/rdy handshake.

Parameters:
- KEY_W, 24, key width in bits; must be a multiple of 8. Key length in bytes is KEY_W/8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  KEY_W  encryption key; key[KEY_W-1:KEY_W-8] is key byte 0 (big-endian).
- s_addr  out  8  S memory address.
- s_rddata  in  8  S memory read data.
- s_wrdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- pt_addr  out  8  plaintext memory address.
- pt_rddata  in  8  plaintext read data.
- ct_addr  out  8  ciphertext memory address.
- ct_wrdata  out  8  ciphertext write data.
- ct_wren  out  1  ciphertext write enable.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Memory timing: all memories are single-port synchronous with 1-cycle read latency. Data for an address presented in cycle N is valid on rddata in cycle N+1.
- A write and a read of the same memory never share a cycle.
- Reset values: rdy=1, s_wren=0, ct_wren=0, all addresses 0, state=IDLE.
- Reset mid-operation:
  - Aborts immediately; IDLE with rdy=1 on the cycle after rst is sampled.
  - No further writes occur.
  - Memory contents are left partially written.
- rst and en in the same cycle: rst wins.
- Handshake and key latching:
  - en is sampled at the clk edge while rdy=1; rdy drops to 0 on the next cycle.
  - key is latched on that same edge; later changes to key are ignored until the next start.
  - en while rdy=0 is ignored.
- Completion: rdy returns to 1 exactly one cycle after the last ct write.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> (ZFILL) -> IDLE.
- INIT:
  - Writes S[i]=i for i=0..255, one write per cycle: 256 cycles.
- KSA, for i=0..255 with j starting at 0:
  - Read S[i].
  - j = (j + S[i] + keybyte[i mod (KEY_W/8)]) mod 256.
  - Read S[j], then write S[i]=old S[j] and S[j]=old S[i].
  - When i=j, the final value equals the original (two writes of the same data are acceptable).
- LEN:
  - Read pt[0] into len.
  - Write ct[0]=len.
- PRGA, for k=1..len with i and j reset to 0 at PRGA entry:
  - i=(i+1) mod 256; read S[i].
  - j=(j+S[i]) mod 256; read S[j]; swap S[i] and S[j].
  - Read S[(S[i]+S[j]) mod 256] using the post-swap values; read pt[k].
  - Write ct[k]=pt[k] XOR pad.
- Arithmetic: all index arithmetic is 8-bit wrap-around. The k counter is 9 bits so that len=255 terminates correctly.
- len=0: PRGA performs no iterations; only ct[0]=0 is written.
- len=255: writes ct[1..255], with no wrap back onto ct[0].
- S memory after a run holds the post-PRGA permutation; it is not restored.

Optional Feature:
- Macro: ARC4_ENC_ZERO_FILL_EN.
- Defined:
  - After PRGA, ZFILL writes ct[k]=0x00 for k=len+1..255, one per cycle.
  - rdy rises one cycle after the ct[255] write.
  - With len=255, ZFILL is skipped.
- Undefined:
  - ZFILL does not exist; ct addresses above len are never written.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release. Expect rdy=1, s_wren=0, ct_wren=0. Pulse en; the next cycle rdy=0.
- Standard vector: key=24'h4B6579 ("Key"); pt = 09 followed by "Plaintext". Expect ct = 09 BB F3 16 E8 D9 40 AF 0A D3, then rdy=1.
- len=0: key=24'h000018, pt[0]=00. Expect exactly one ct write (ct[0]=00). Without the macro, no ct writes to addresses 1..255. With the macro, ct[1..255]=00.
- Round trip: key=24'h000018, 40-byte ASCII message. Feed the ct contents to the existing decrypt block with the same key. Expect pt reproduced byte-exact; len=255 case as well.
- Abort and ignore:
  - Assert rst mid-KSA: next cycle rdy=1 and no writes.
  - Pulse en while rdy=0 during a run: no restart; output still matches the Standard-vector ct.
  - Change key mid-run: no effect; output still matches the Standard-vector ct.
